// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI helper types for the burst address generator.
// Holds the burst encoding, the address-channel request struct and the
// per-beat next-address function.
// The WRAP arithmetic in axi_next_addr exists only when AXI_WRAP_BURST_EN is
// defined. Without it, WRAP falls through to INCR address math.
package axi_burst_addr_gen_pkg;

  localparam int AXI_ADDR_LEN = 32;
  localparam int AXI_DATA_LEN = 64;
  localparam int AXI_ID_LEN   = 4;
  localparam int MAX_SIZE     = $clog2(AXI_DATA_LEN / 8);

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    logic [AXI_ID_LEN-1:0]   id;
    logic [AXI_ADDR_LEN-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    burst_t                  burst;
  } AxDATA_t;

  localparam int AxDATA_W = $bits(AxDATA_t);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } gen_state_t;

  // Address of the beat following 'addr' within a burst of the given shape.
  // INCR aligns down to the beat width before stepping, so an unaligned first
  // beat is followed by an aligned second beat. RSVD follows INCR math; the
  // burst is flagged as an error anyway.
  function automatic logic [AXI_ADDR_LEN-1:0] axi_next_addr(
    input logic [AXI_ADDR_LEN-1:0] addr,
    input logic [2:0]              size,
    input logic [7:0]              len,
    input burst_t                  burst
  );
    logic [AXI_ADDR_LEN-1:0] bytes;
    logic [AXI_ADDR_LEN-1:0] next;
`ifdef AXI_WRAP_BURST_EN
    logic [AXI_ADDR_LEN-1:0] wmask;
`endif
    bytes = AXI_ADDR_LEN'(1) << size;
    next  = (addr & ~(bytes - 1'b1)) + bytes;
`ifdef AXI_WRAP_BURST_EN
    wmask = (bytes * (AXI_ADDR_LEN'(len) + 1'b1)) - 1'b1;
`endif
    case (burst)
      FIXED: next = addr;
`ifdef AXI_WRAP_BURST_EN
      WRAP:  next = (addr & ~wmask) | ((addr + bytes) & wmask);
`endif
      default: next = (addr & ~(bytes - 1'b1)) + bytes;
    endcase
`ifndef AXI_WRAP_BURST_EN
    if (len == 8'hFF) next = next;
`endif
    return next;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// AXI4 address-channel burst expander.
// Takes one AW/AR request and emits one address per beat to the backend.
// A burst-shape error is computed when the request is accepted, and it is held for the whole burst.
// The beat count always stays len+1, so the data channels stay in step.
// A new request can be accepted on the last-beat handshake, so back-to-back bursts need no idle cycle.
// Optional feature: define AXI_WRAP_BURST_EN to decode WRAP bursts. Without it,
// WRAP is reported as an error and its addresses follow INCR math.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_LEN = AXI_ADDR_LEN,
  parameter int DATA_LEN = AXI_DATA_LEN,
  parameter int ID_LEN   = AXI_ID_LEN
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ax_valid,
  output logic                ax_ready,
  input  AxDATA_t             ax_req,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [ID_LEN-1:0]   beat_id,
  output logic [ADDR_LEN-1:0] beat_addr,
  output logic [7:0]          beat_idx,
  output logic                beat_last,
  output logic                beat_err
);

  localparam int MAX_SZ = $clog2(DATA_LEN / 8);

  gen_state_t          state_q, state_d;
  logic [ID_LEN-1:0]   id_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  burst_t              burst_q;
  logic [7:0]          idx_q;
  logic                err_q;

  logic                load;
  logic                advance;
  logic                last_beat;

  logic [ADDR_LEN-1:0] req_addr;
  logic [ADDR_LEN-1:0] req_bytes;
  logic [ADDR_LEN-1:0] req_last_addr;
  logic                req_err;
  logic [ADDR_LEN-1:0] next_addr;

  assign last_beat = (state_q == BURST) && (idx_q == len_q);
  assign next_addr = ADDR_LEN'(axi_next_addr(AXI_ADDR_LEN'(addr_q), size_q, len_q, burst_q));

  // Classify the incoming request as legal or illegal before it is registered.
  always_comb begin
    req_addr      = ADDR_LEN'(ax_req.addr);
    req_bytes     = ADDR_LEN'(1) << ax_req.size;
    req_last_addr = (req_addr & ~(req_bytes - 1'b1)) + (ADDR_LEN'(ax_req.len) * req_bytes);
    req_err       = 1'b0;
    if (ax_req.size > 3'(MAX_SZ)) req_err = 1'b1;
    case (ax_req.burst)
      INCR: begin
        if (req_addr[ADDR_LEN-1:12] != req_last_addr[ADDR_LEN-1:12]) req_err = 1'b1;
      end
      WRAP: begin
`ifdef AXI_WRAP_BURST_EN
        if (!((ax_req.len == 8'd1) || (ax_req.len == 8'd3) ||
              (ax_req.len == 8'd7) || (ax_req.len == 8'd15))) req_err = 1'b1;
        if ((req_addr & (req_bytes - 1'b1)) != '0) req_err = 1'b1;
`else
        req_err = 1'b1;
`endif
      end
      RSVD:    req_err = 1'b1;
      default: ;
    endcase
  end

  // Next-state and handshake decode; the last-beat handshake doubles as a request slot.
  always_comb begin
    state_d    = state_q;
    ax_ready   = 1'b0;
    beat_valid = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        ax_ready = 1'b1;
        if (ax_valid) begin
          load    = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        beat_valid = 1'b1;
        if (beat_ready) begin
          if (last_beat) begin
            ax_ready = 1'b1;
            if (ax_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ARESET) begin
      ax_ready = 1'b0;
      load     = 1'b0;
    end
  end

  // State register; reset discards any burst in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Burst context and beat counter: loaded on accept, stepped on each accepted beat.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= FIXED;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      id_q    <= ID_LEN'(ax_req.id);
      addr_q  <= req_addr;
      len_q   <= ax_req.len;
      size_q  <= ax_req.size;
      burst_q <= ax_req.burst;
      idx_q   <= '0;
      err_q   <= req_err;
    end else if (advance) begin
      idx_q  <= idx_q + 8'd1;
      addr_q <= next_addr;
    end
  end

  assign beat_id   = id_q;
  assign beat_addr = addr_q;
  assign beat_idx  = idx_q;
  assign beat_last = last_beat;
  assign beat_err  = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen.
// A table of requests drives the DUT, and the expected beats are queued at each handshake.
// A negedge monitor pops an expected beat for every accepted beat and compares the two.
// Hand-written sequences cover several cases:
// - reset
// - back-to-back single-beat bursts
// - backpressure stalls
// - reset in the middle of a burst
// Expected WRAP rows follow AXI_WRAP_BURST_EN.
module tb_axi_burst_addr_gen;
  import axi_burst_addr_gen_pkg::*;

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    burst_t           burst;
    logic             err;
    logic             chk;
    logic [3:0][31:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic        err;
    logic        chk;
  } exp_beat_t;

  logic        ACLK;
  logic        ARESET;
  logic        ax_valid;
  logic        ax_ready;
  AxDATA_t     ax_req;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        beat_err;

  int checks = 0;
  int errors = 0;
  exp_beat_t sb[$];
  exp_beat_t monE;
  vec_t table_v[8];
  int numVec;

  axi_burst_addr_gen dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ax_valid   (ax_valid),
    .ax_ready   (ax_ready),
    .ax_req     (ax_req),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_err   (beat_err)
  );

  // Free-running clock.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mkVec(logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                                 logic [2:0] size, burst_t burst, logic err, logic chk,
                                 logic [31:0] a0, logic [31:0] a1,
                                 logic [31:0] a2, logic [31:0] a3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.err = err; v.chk = chk;
    v.exp[0] = a0; v.exp[1] = a1; v.exp[2] = a2; v.exp[3] = a3;
    return v;
  endfunction

  // Every accepted beat is matched against the oldest expected beat.
  always @(negedge ACLK) begin
    if (!ARESET && beat_valid && beat_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        monE = sb.pop_front();
        checkOutput($sformatf("beat_id[%0d]", monE.idx), 64'(beat_id), 64'(monE.id));
        if (monE.chk)
          checkOutput($sformatf("beat_addr[%0d]", monE.idx), 64'(beat_addr), 64'(monE.addr));
        checkOutput($sformatf("beat_idx[%0d]", monE.idx), 64'(beat_idx), 64'(monE.idx));
        checkOutput($sformatf("beat_last[%0d]", monE.idx), 64'(beat_last), 64'(monE.last));
        checkOutput($sformatf("beat_err[%0d]", monE.idx), 64'(beat_err), 64'(monE.err));
      end
    end
  end

  task automatic applyStimulus(input vec_t v, output int waits);
    bit hs;
    exp_beat_t e;
    ax_req.id    = v.id;
    ax_req.addr  = v.addr;
    ax_req.len   = v.len;
    ax_req.size  = v.size;
    ax_req.burst = v.burst;
    ax_valid     = 1'b1;
    waits = 0;
    hs    = 1'b0;
    while (!hs && waits < 100) begin
      @(negedge ACLK);
      hs = ax_ready;
      if (hs) begin
        for (int n = 0; n <= int'(v.len); n++) begin
          e.id   = v.id;
          e.addr = v.exp[n];
          e.idx  = 8'(n);
          e.last = (n == int'(v.len));
          e.err  = v.err;
          e.chk  = v.chk;
          sb.push_back(e);
        end
      end
      @(posedge ACLK); #1;
      if (!hs) waits++;
    end
    if (!hs) checkOutput("ax_handshake", 64'(hs), 64'd1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
  endtask

  // Main test sequence.
  initial begin
    int waits;
    vec_t v;

    numVec = 0;
    table_v[numVec++] = mkVec(4'h1, 32'h1000, 8'd3, 3'd3, INCR,  1'b0, 1'b1,
                              32'h1000, 32'h1008, 32'h1010, 32'h1018);
`ifdef AXI_WRAP_BURST_EN
    table_v[numVec++] = mkVec(4'h2, 32'h1018, 8'd3, 3'd3, WRAP,  1'b0, 1'b1,
                              32'h1018, 32'h1000, 32'h1008, 32'h1010);
    table_v[numVec++] = mkVec(4'h3, 32'h1001, 8'd3, 3'd2, WRAP,  1'b1, 1'b1,
                              32'h1001, 32'h1005, 32'h1009, 32'h100D);
`else
    table_v[numVec++] = mkVec(4'h2, 32'h1018, 8'd3, 3'd3, WRAP,  1'b1, 1'b1,
                              32'h1018, 32'h1020, 32'h1028, 32'h1030);
    table_v[numVec++] = mkVec(4'h3, 32'h1001, 8'd3, 3'd2, WRAP,  1'b1, 1'b1,
                              32'h1001, 32'h1004, 32'h1008, 32'h100C);
`endif
    table_v[numVec++] = mkVec(4'h4, 32'h2004, 8'd2, 3'd2, FIXED, 1'b0, 1'b1,
                              32'h2004, 32'h2004, 32'h2004, 32'h0);
    table_v[numVec++] = mkVec(4'h5, 32'h1003, 8'd1, 3'd2, INCR,  1'b0, 1'b1,
                              32'h1003, 32'h1004, 32'h0, 32'h0);
    table_v[numVec++] = mkVec(4'h6, 32'h0FF8, 8'd1, 3'd3, INCR,  1'b1, 1'b1,
                              32'h0FF8, 32'h1000, 32'h0, 32'h0);
    table_v[numVec++] = mkVec(4'h7, 32'h3000, 8'd1, 3'd4, INCR,  1'b1, 1'b1,
                              32'h3000, 32'h3010, 32'h0, 32'h0);
    table_v[numVec++] = mkVec(4'h8, 32'h4000, 8'd1, 3'd2, RSVD,  1'b1, 1'b0,
                              32'h0, 32'h0, 32'h0, 32'h0);

    ARESET     = 1'b1;
    ax_valid   = 1'b0;
    ax_req     = '0;
    beat_ready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset_ax_ready",   64'(ax_ready),   64'd0);
    checkOutput("reset_beat_valid", 64'(beat_valid), 64'd0);
    checkOutput("reset_beat_last",  64'(beat_last),  64'd0);
    checkOutput("reset_beat_err",   64'(beat_err),   64'd0);
    checkOutput("reset_beat_addr",  64'(beat_addr),  64'd0);
    checkOutput("reset_beat_idx",   64'(beat_idx),   64'd0);
    checkOutput("reset_beat_id",    64'(beat_id),    64'd0);
    ARESET = 1'b0;
    #1;
    checkOutput("idle_ax_ready", 64'(ax_ready), 64'd1);

    for (int i = 0; i < numVec; i++) applyStimulus(table_v[i], waits);
    ax_valid = 1'b0;
    waitDrain("table_drain");

    for (int k = 0; k < 4; k++) begin
      v = mkVec(4'(9 + k), 32'h5000 + 32'(k * 8), 8'd0, 3'd3, INCR, 1'b0, 1'b1,
                32'h5000 + 32'(k * 8), 32'h0, 32'h0, 32'h0);
      applyStimulus(v, waits);
      checkOutput($sformatf("b2b_wait[%0d]", k), 64'(waits), 64'd0);
      checkOutput($sformatf("b2b_valid[%0d]", k), 64'(beat_valid), 64'd1);
    end
    ax_valid = 1'b0;
    waitDrain("b2b_drain");

    beat_ready = 1'b0;
    v = mkVec(4'hD, 32'h6000, 8'd3, 3'd3, INCR, 1'b0, 1'b1,
              32'h6000, 32'h6008, 32'h6010, 32'h6018);
    applyStimulus(v, waits);
    ax_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      checkOutput($sformatf("stall_valid[%0d]", c), 64'(beat_valid), 64'd1);
      checkOutput($sformatf("stall_addr[%0d]", c),  64'(beat_addr),  64'h6000);
      checkOutput($sformatf("stall_idx[%0d]", c),   64'(beat_idx),   64'd0);
      checkOutput($sformatf("stall_ready[%0d]", c), 64'(ax_ready),   64'd0);
    end
    @(posedge ACLK); #1;
    beat_ready = 1'b1;
    waitDrain("stall_drain");

    v = mkVec(4'hE, 32'h7000, 8'd7, 3'd2, INCR, 1'b0, 1'b0,
              32'h0, 32'h0, 32'h0, 32'h0);
    applyStimulus(v, waits);
    ax_valid = 1'b0;
    for (int c = 0; c < 20 && beat_idx != 8'd2; c++) begin
      @(posedge ACLK); #1;
    end
    checkOutput("mid_idx_before_reset", 64'(beat_idx), 64'd2);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("mid_reset_valid", 64'(beat_valid), 64'd0);
    checkOutput("mid_reset_idx",   64'(beat_idx),   64'd0);
    checkOutput("mid_reset_addr",  64'(beat_addr),  64'd0);
    checkOutput("mid_reset_ready", 64'(ax_ready),   64'd0);
    sb.delete();
    ARESET = 1'b0;
    #1;
    checkOutput("post_reset_idle", 64'(ax_ready), 64'd1);
    v = mkVec(4'hF, 32'h8000, 8'd1, 3'd2, INCR, 1'b0, 1'b1,
              32'h8000, 32'h8004, 32'h0, 32'h0);
    applyStimulus(v, waits);
    ax_valid = 1'b0;
    checkOutput("post_reset_idx0", 64'(beat_idx), 64'd0);
    waitDrain("post_reset_drain");

    repeat (2) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
